// File: rtl/morse_rx.sv
// Morse receiver: times keyed marks and spaces in Morse units, classifies dot/dash,
// gathers up to five symbols per character and reports the code at the letter gap.
module morse_rx #(
    parameter int UNIT_CYCLES = 12_500_000,
    parameter int UCNT_W      = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KEY_IN,
    output logic [4:0] SYM_CODE,
    output logic [2:0] SYM_LEN,
    output logic       CHAR_VALID,
    output logic       WORD_GAP,
    output logic       ERR,
    output logic       BUSY
);

    localparam int PRESC_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(UNIT_CYCLES - 1);
    localparam logic [UCNT_W-1:0]  UCNT_MAX  = '1;
    localparam logic [UCNT_W-1:0]  U_DASH    = UCNT_W'(2);
    localparam logic [UCNT_W-1:0]  U_BAD     = UCNT_W'(7);
    localparam logic [UCNT_W-1:0]  U_LETTER  = UCNT_W'(3);
    localparam logic [UCNT_W-1:0]  U_WORD    = UCNT_W'(7);

    typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE} state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q, prev_q;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [UCNT_W-1:0]   units_q, units_d;
    logic [4:0]          buf_q, buf_d;
    logic [2:0]          len_q, len_d;
    logic                ovf_q, ovf_d;
    logic                cv_seen_q, cv_seen_d;
    logic [4:0]          code_q, code_d;
    logic [2:0]          slen_q, slen_d;
    logic                cv_q, cv_d;
    logic                err_q, err_d;
    logic                wg_q, wg_d;

    logic                rise, fall, wrap;
    logic [UCNT_W-1:0]   units_inc;
    logic [4:0]          sym_we;

    assign rise      = sync2_q & ~prev_q;
    assign fall      = ~sync2_q & prev_q;
    assign wrap      = (presc_q == PRESC_MAX);
    assign units_inc = (units_q == UCNT_MAX) ? units_q : units_q + UCNT_W'(1);

    // One-hot write enable: the next symbol lands at bit position len_q.
    for (genvar gi = 0; gi < 5; gi++) begin : g_we
        assign sym_we[gi] = (len_q == 3'(gi));
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        units_d   = units_q;
        buf_d     = buf_q;
        len_d     = len_q;
        ovf_d     = ovf_q;
        cv_seen_d = cv_seen_q;
        code_d    = code_q;
        slen_d    = slen_q;
        cv_d      = 1'b0;
        err_d     = 1'b0;
        wg_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_MARK;
                    presc_d = '0;
                    units_d = '0;
                end
            end
            S_MARK: begin
                if (fall) begin
                    if (units_q >= U_BAD || len_q == 3'd5) begin
                        ovf_d = 1'b1;
                    end else begin
                        for (int i = 0; i < 5; i++) begin
                            if (sym_we[i]) buf_d[i] = (units_q >= U_DASH);
                        end
                        len_d = len_q + 3'd1;
                    end
                    state_d = S_SPACE;
                    presc_d = '0;
                    units_d = '0;
                end else begin
                    presc_d = wrap ? '0 : presc_q + PRESC_W'(1);
                    if (wrap) units_d = units_inc;
                end
            end
            S_SPACE: begin
                if (rise) begin
                    // Buffer is kept: either still collecting, or already flushed at the letter gap.
                    state_d = S_MARK;
                    presc_d = '0;
                    units_d = '0;
                end else begin
                    presc_d = wrap ? '0 : presc_q + PRESC_W'(1);
                    if (wrap) begin
                        units_d = units_inc;
                        if (units_q == U_LETTER - UCNT_W'(1)) begin
                            if (ovf_q) begin
                                err_d = 1'b1;
                            end else begin
                                code_d    = buf_q;
                                slen_d    = len_q;
                                cv_d      = 1'b1;
                                cv_seen_d = 1'b1;
                            end
                            buf_d = '0;
                            len_d = '0;
                            ovf_d = 1'b0;
                        end
                        if (units_q == U_WORD - UCNT_W'(1)) begin
                            wg_d      = cv_seen_q;
                            cv_seen_d = 1'b0;
                            state_d   = S_IDLE;
                            presc_d   = '0;
                            units_d   = '0;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            presc_q   <= '0;
            units_q   <= '0;
            buf_q     <= '0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            cv_seen_q <= 1'b0;
            code_q    <= '0;
            slen_q    <= '0;
            cv_q      <= 1'b0;
            err_q     <= 1'b0;
            wg_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= KEY_IN;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            presc_q   <= presc_d;
            units_q   <= units_d;
            buf_q     <= buf_d;
            len_q     <= len_d;
            ovf_q     <= ovf_d;
            cv_seen_q <= cv_seen_d;
            code_q    <= code_d;
            slen_q    <= slen_d;
            cv_q      <= cv_d;
            err_q     <= err_d;
            wg_q      <= wg_d;
        end
    end

    assign SYM_CODE   = code_q;
    assign SYM_LEN    = slen_q;
    assign CHAR_VALID = cv_q;
    assign ERR        = err_q;
    assign WORD_GAP   = wg_q;
    assign BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_morse_rx.sv
// Directed bench for morse_rx with a 4-cycle Morse unit.
module tb_morse_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       KEY_IN = 1'b0;
    logic [4:0] SYM_CODE;
    logic [2:0] SYM_LEN;
    logic       CHAR_VALID, WORD_GAP, ERR, BUSY;

    int tests = 0;
    int fails = 0;
    int cv_cnt = 0, err_cnt = 0, wg_cnt = 0, multi_cnt = 0;
    int cv_b, err_b, wg_b;

    morse_rx #(.UNIT_CYCLES(4), .UCNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .KEY_IN(KEY_IN),
        .SYM_CODE(SYM_CODE), .SYM_LEN(SYM_LEN),
        .CHAR_VALID(CHAR_VALID), .WORD_GAP(WORD_GAP), .ERR(ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (CHAR_VALID) cv_cnt++;
        if (ERR) err_cnt++;
        if (WORD_GAP) wg_cnt++;
        if ((32'(CHAR_VALID) + 32'(ERR) + 32'(WORD_GAP)) > 1) multi_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic key_for(input logic level, input int n);
        KEY_IN = level;
        repeat (n) @(negedge CLK);
    endtask

    task automatic snap();
        cv_b  = cv_cnt;
        err_b = err_cnt;
        wg_b  = wg_cnt;
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_code", 32'(SYM_CODE), 0);
        check("rst_len", 32'(SYM_LEN), 0);
        check("rst_pulses", 32'({CHAR_VALID, ERR, WORD_GAP}), 0);
        check("rst_busy", 32'(BUSY), 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // 1: 'A' = dot dash
        snap();
        key_for(1, 4); key_for(0, 4); key_for(1, 12); key_for(0, 16);
        key_for(0, 30);
        check("A_cv", 32'(cv_cnt - cv_b), 1);
        check("A_err", 32'(err_cnt - err_b), 0);
        check("A_code", 32'(SYM_CODE), 32'b00010);
        check("A_len", 32'(SYM_LEN), 2);
        check("A_wg", 32'(wg_cnt - wg_b), 1);
        check("A_idle", 32'(BUSY), 0);

        // 2: 'E' then long idle, only one word gap
        snap();
        key_for(1, 4); key_for(0, 40);
        check("E_cv", 32'(cv_cnt - cv_b), 1);
        check("E_code", 32'(SYM_CODE), 0);
        check("E_len", 32'(SYM_LEN), 1);
        check("E_wg", 32'(wg_cnt - wg_b), 1);
        key_for(0, 40);
        check("E_wg_once", 32'(wg_cnt - wg_b), 1);

        // 3: six dots overflow
        snap();
        for (int i = 0; i < 6; i++) begin
            key_for(1, 4); key_for(0, 4);
        end
        key_for(0, 12); key_for(0, 30);
        check("ovf_err", 32'(err_cnt - err_b), 1);
        check("ovf_cv", 32'(cv_cnt - cv_b), 0);
        check("ovf_code", 32'(SYM_CODE), 0);
        check("ovf_len", 32'(SYM_LEN), 1);
        check("ovf_wg", 32'(wg_cnt - wg_b), 0);

        // 4: overlong mark, then 'T'
        snap();
        key_for(1, 32); key_for(0, 16);
        check("long_err", 32'(err_cnt - err_b), 1);
        check("long_cv", 32'(cv_cnt - cv_b), 0);
        key_for(1, 12); key_for(0, 40);
        check("T_cv", 32'(cv_cnt - cv_b), 1);
        check("T_code", 32'(SYM_CODE), 1);
        check("T_len", 32'(SYM_LEN), 1);
        check("T_err", 32'(err_cnt - err_b), 1);

        // 5: reset during the dash of 'A'
        snap();
        key_for(1, 4); key_for(0, 4); key_for(1, 6);
        RST = 1'b1; KEY_IN = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        check("mid_code", 32'(SYM_CODE), 0);
        check("mid_len", 32'(SYM_LEN), 0);
        check("mid_busy", 32'(BUSY), 0);
        key_for(0, 40);
        check("mid_quiet", 32'((cv_cnt - cv_b) + (err_cnt - err_b) + (wg_cnt - wg_b)), 0);
        key_for(1, 4); key_for(0, 40);
        check("mid_fresh_cv", 32'(cv_cnt - cv_b), 1);
        check("mid_fresh_len", 32'(SYM_LEN), 1);

        // 6: key held high through reset release
        RST = 1'b1; KEY_IN = 1'b1;
        repeat (3) @(negedge CLK);
        snap();
        RST = 1'b0;
        @(posedge CLK);
        @(posedge CLK); #1;
        check("rel_busy_e2", 32'(BUSY), 0);
        check("rel_len", 32'(SYM_LEN), 0);
        @(posedge CLK); #1;
        check("rel_busy_e3", 32'(BUSY), 1);
        @(posedge CLK);
        @(negedge CLK);
        key_for(0, 40);
        check("rel_cv", 32'(cv_cnt - cv_b), 1);
        check("rel_code", 32'(SYM_CODE), 0);
        check("rel_len1", 32'(SYM_LEN), 1);

        check("no_overlap", 32'(multi_cnt), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
